// File: rtl/secded_pkg.sv
// secded_pkg
//   Shared definitions for the pipelined SEC/SEC-DED corrector.
//   - err_e    : per-word error class reported on out_err.
//   - ham_w    : number of Hamming check bits needed for a data width.
//   - data_pos : codeword position (1-based) that holds data bit i.
//                Data bits fill the non-power-of-two positions in order,
//                so bit 0 -> 3, bit 1 -> 5, bit 2 -> 6, bit 3 -> 7, ...
package secded_pkg;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,  // clean word
      ERR_DATA = 2'b01,  // single data-bit error (correctable)
      ERR_CHK  = 2'b10,  // check-bit error, data intact
      ERR_UNC  = 2'b11   // uncorrectable
   } err_e;

   // Smallest r with 2^r >= data_w + r + 1.
   function automatic int ham_w(input int data_w);
      int r;
      r = 1;
      for (int i = 0; i < 8; i++) begin
         if ((1 << r) < data_w + r + 1) r = r + 1;
      end
      return r;
   endfunction

   // Position of data bit i among the non-power-of-two codeword slots.
   function automatic int data_pos(input int i);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 3; p < 128; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == i && pos == 0) pos = p;
            cnt = cnt + 1;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/secded_pipe_corrector_syndrome.sv
// secded_syndrome
//   Combinational syndrome / overall-parity evaluator for one received word.
//   Ports:
//     data       in  DATA_W  received data bits
//     chk        in  CHK_W   received check bits (Hamming bits, then the
//                            overall parity bit when DED_EN=1)
//     syndrome   out HAM_W   XOR of the indices of all set codeword positions
//     parity_err out 1       overall parity mismatch (always 0 when DED_EN=0)
module secded_syndrome
   import secded_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  DED_EN = 1,
   localparam int HAM_W  = ham_w(DATA_W),
   localparam int CHK_W  = HAM_W + DED_EN
) (
   input  logic [DATA_W-1:0] data,
   input  logic [CHK_W-1:0]  chk,
   output logic [HAM_W-1:0]  syndrome,
   output logic              parity_err
);

   // Each set data bit contributes its codeword index to the syndrome.
   logic [HAM_W-1:0] term [DATA_W];

   for (genvar i = 0; i < DATA_W; i++) begin : g_term
      localparam int POS = data_pos(i);
      assign term[i] = data[i] ? HAM_W'(POS) : '0;
   end

   // Hamming check bit k sits at position 2^k, so its index contribution
   // is exactly bit k: the check bits can be XORed in as a vector.
   always_comb begin
      syndrome = chk[HAM_W-1:0];
      for (int i = 0; i < DATA_W; i++) begin
         syndrome = syndrome ^ term[i];
      end
   end

   // The stored overall bit makes the full codeword even, so any odd
   // number of flips shows up as a set reduction XOR.
   if (DED_EN != 0) begin : g_ded
      assign parity_err = (^data) ^ (^chk);
   end else begin : g_sec
      assign parity_err = 1'b0;
   end

endmodule

// File: rtl/secded_pipe_corrector.sv
// secded_pipe_corrector
//   Two-stage pipelined SEC / SEC-DED decoder with valid/ready handshake,
//   optional correction, per-word error class and saturating error counters.
//   Ports:
//     clk, rst_n              clock, synchronous active-low reset
//     in_valid/in_ready       input handshake
//     in_data, in_chk         received data and check bits
//     corr_en                 apply correction to this word (sampled with it)
//     out_valid/out_ready     output handshake
//     out_data                corrected (or raw) data
//     out_syndrome, out_err   Hamming syndrome and error class of the word
//     cnt_clr                 synchronous clear of both counters
//     cnt_corr, cnt_unc       accepted words with class 01/10, resp. 11
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. The pipeline stalls globally: both stages move only when
//   advance = !out_valid || out_ready, and in_ready is that same signal.
//   out_valid, once raised, holds with stable out_* until out_ready is seen.
module secded_pipe_corrector
   import secded_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  DED_EN = 1,
   parameter int  CNT_W  = 16,
   localparam int HAM_W  = ham_w(DATA_W),
   localparam int CHK_W  = HAM_W + DED_EN,
   localparam int N      = DATA_W + HAM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CHK_W-1:0]  in_chk,
   input  logic              corr_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [HAM_W-1:0]  out_syndrome,
   output logic [1:0]        out_err,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_unc
);

   localparam logic [HAM_W-1:0] N_MAX = HAM_W'(N);

   logic              advance;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [CHK_W-1:0]  s1_chk;
   logic              s1_corr_en;

   logic [HAM_W-1:0]  syn;
   logic              pm;
   logic              syn_pow2;
   logic              syn_in_range;
   err_e              cls;
   logic [DATA_W-1:0] flip_mask;
   logic [DATA_W-1:0] fixed_data;

   logic              accept;
   logic              corr_evt;
   logic              unc_evt;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // ---------------- Stage 1: capture received word ----------------
   // On advance S1 always takes in_valid, so an idle input leaves a bubble;
   // during a stall S1 simply holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_data    <= '0;
         s1_chk     <= '0;
         s1_corr_en <= 1'b0;
      end else if (advance) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data    <= in_data;
            s1_chk     <= in_chk;
            s1_corr_en <= corr_en;
         end
      end
   end

   secded_syndrome #(
      .DATA_W (DATA_W),
      .DED_EN (DED_EN)
   ) u_syndrome (
      .data       (s1_data),
      .chk        (s1_chk),
      .syndrome   (syn),
      .parity_err (pm)
   );

   // ---------------- Classification ----------------
   // A nonzero power-of-two syndrome addresses a Hamming check bit.
   assign syn_pow2     = (syn & (syn - HAM_W'(1))) == '0;
   assign syn_in_range = syn <= N_MAX;

   always_comb begin
      cls = ERR_NONE;
      if (syn == '0) begin
         // Only the overall parity bit itself can be wrong here.
         if (pm) cls = ERR_CHK;
      end else if (!syn_in_range) begin
         cls = ERR_UNC;
      end else if ((DED_EN != 0) && !pm) begin
         // Even number of flips with a nonzero syndrome: double error.
         cls = ERR_UNC;
      end else if (syn_pow2) begin
         cls = ERR_CHK;
      end else begin
         cls = ERR_DATA;
      end
   end

   // ---------------- Correction ----------------
   for (genvar i = 0; i < DATA_W; i++) begin : g_flip
      localparam int POS = data_pos(i);
      assign flip_mask[i] = (syn == HAM_W'(POS));
   end

   assign fixed_data = ((cls == ERR_DATA) && s1_corr_en) ? (s1_data ^ flip_mask)
                                                         : s1_data;

   // ---------------- Stage 2: output registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_syndrome <= '0;
         out_err      <= ERR_NONE;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data     <= fixed_data;
            out_syndrome <= syn;
            out_err      <= cls;
         end
      end
   end

   // ---------------- Error counters ----------------
   // Counted at output acceptance so a stalled word is seen exactly once.
   assign accept   = out_valid && out_ready;
   assign corr_evt = accept && ((out_err == ERR_DATA) || (out_err == ERR_CHK));
   assign unc_evt  = accept && (out_err == ERR_UNC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_corr <= '0;
         cnt_unc  <= '0;
      end else if (cnt_clr) begin
         cnt_corr <= '0;
         cnt_unc  <= '0;
      end else begin
         if (corr_evt && (cnt_corr != '1)) cnt_corr <= cnt_corr + CNT_W'(1);
         if (unc_evt && (cnt_unc != '1))   cnt_unc  <= cnt_unc + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_secded_pipe_corrector.sv
// tb_secded_pipe_corrector
//   Bench for secded_pipe_corrector at DATA_W=32, DED_EN=1, CNT_W=4.
//   Directed vector table, multi-cycle sequences (saturation, clear
//   priority, backpressure, mid-stream reset) and a random phase, all
//   cross-checked by a codeword-level reference model and scoreboard.
module tb_secded_pipe_corrector;

   localparam int DATA_W = 32;
   localparam int DED_EN = 1;
   localparam int CNT_W  = 4;
   localparam int HAM_W  = 6;
   localparam int CHK_W  = 7;
   localparam int N      = 38;
   localparam int W      = DATA_W + HAM_W + 2;
   localparam int CMAX   = (1 << CNT_W) - 1;

   // ---------------- Clock / reset ----------------
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic [CHK_W-1:0]  in_chk = '0;
   logic              corr_en = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [HAM_W-1:0]  out_syndrome;
   logic [1:0]        out_err;
   logic              cnt_clr = 1'b0;
   logic [CNT_W-1:0]  cnt_corr;
   logic [CNT_W-1:0]  cnt_unc;

   always #5 clk = ~clk;

   secded_pipe_corrector #(
      .DATA_W (DATA_W),
      .DED_EN (DED_EN),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_chk       (in_chk),
      .corr_en      (corr_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_syndrome (out_syndrome),
      .out_err      (out_err),
      .cnt_clr      (cnt_clr),
      .cnt_corr     (cnt_corr),
      .cnt_unc      (cnt_unc)
   );

   // ---------------- Bookkeeping ----------------
   int n_vec = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // ---------------- Reference model ----------------
   function automatic bit is_pow2(input int p);
      return (p > 0) && ((p & (p - 1)) == 0);
   endfunction

   function automatic int log2i(input int p);
      for (int k = 0; k < 8; k++) if ((1 << k) == p) return k;
      return 0;
   endfunction

   // Lay the word out as codeword positions 1..N, XOR the indices of the
   // set positions, classify, and fix the addressed position if allowed.
   function automatic logic [W-1:0] ref_decode(input logic [DATA_W-1:0] d,
                                                input logic [CHK_W-1:0] c,
                                                input logic ce);
      logic cw [64];
      int j;
      int syn;
      logic par;
      logic [1:0] cls;
      logic [DATA_W-1:0] od;
      for (int p = 0; p < 64; p++) cw[p] = 1'b0;
      j = 0;
      syn = 0;
      par = c[HAM_W];
      for (int p = 1; p <= N; p++) begin
         if (is_pow2(p)) cw[p] = c[log2i(p)];
         else begin
            cw[p] = d[j];
            j++;
         end
         if (cw[p]) begin
            syn = syn ^ p;
            par = ~par;
         end
      end
      if (syn == 0)       cls = par ? 2'b10 : 2'b00;
      else if (syn > N)   cls = 2'b11;
      else if (!par)      cls = 2'b11;
      else                cls = is_pow2(syn) ? 2'b10 : 2'b01;
      if (cls == 2'b01 && ce) cw[syn] = ~cw[syn];
      j = 0;
      od = '0;
      for (int p = 1; p <= N; p++) begin
         if (!is_pow2(p)) begin
            od[j] = cw[p];
            j++;
         end
      end
      return {od, syn[HAM_W-1:0], cls};
   endfunction

   // Random data encoded into a codeword, then nerr random positions flipped
   // (position N+1 stands for the overall parity bit).
   task automatic gen_word(input int nerr, output logic [DATA_W-1:0] d, output logic [CHK_W-1:0] c);
      logic cw [64];
      logic [DATA_W-1:0] d0;
      int s;
      int j;
      logic par;
      d0 = $urandom;
      for (int p = 0; p < 64; p++) cw[p] = 1'b0;
      j = 0;
      s = 0;
      for (int p = 1; p <= N; p++) begin
         if (!is_pow2(p)) begin
            cw[p] = d0[j];
            j++;
            if (cw[p]) s = s ^ p;
         end
      end
      for (int k = 0; k < HAM_W; k++) cw[1 << k] = s[k];
      par = 1'b0;
      for (int p = 1; p <= N; p++) par = par ^ cw[p];
      cw[N + 1] = par;
      for (int e = 0; e < nerr; e++) begin
         int p;
         p = $urandom_range(1, N + 1);
         cw[p] = ~cw[p];
      end
      j = 0;
      d = '0;
      c = '0;
      for (int p = 1; p <= N; p++) begin
         if (is_pow2(p)) c[log2i(p)] = cw[p];
         else begin
            d[j] = cw[p];
            j++;
         end
      end
      c[HAM_W] = cw[N + 1];
   endtask

   // ---------------- Scoreboard / monitor ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   logic [W-1:0] hold_val;
   bit           hold_prev = 0;
   bit           mon_en = 0;
   int           m_corr = 0;
   int           m_unc = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("cnt_corr", 64'(cnt_corr), 64'(m_corr));
         check("cnt_unc", 64'(cnt_unc), 64'(m_unc));
         check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
         if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_word", 64'({out_data, out_syndrome, out_err}), 64'(hold_val));
         end
         if (!rst_n) begin
            exp_q.delete();
            m_corr = 0;
            m_unc = 0;
            hold_prev = 0;
         end else begin
            mon_e = '0;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
               else begin
                  mon_e = exp_q.pop_front();
                  check("out_word", 64'({out_data, out_syndrome, out_err}), 64'(mon_e));
               end
            end
            if (cnt_clr) begin
               m_corr = 0;
               m_unc = 0;
            end else if (out_valid && out_ready) begin
               if ((mon_e[1:0] == 2'b01 || mon_e[1:0] == 2'b10) && m_corr < CMAX) m_corr++;
               if (mon_e[1:0] == 2'b11 && m_unc < CMAX) m_unc++;
            end
            hold_prev = out_valid && !out_ready;
            hold_val = {out_data, out_syndrome, out_err};
            if (in_valid && in_ready) exp_q.push_back(ref_decode(in_data, in_chk, corr_en));
         end
      end
   end

   // ---------------- Driver tasks ----------------
   typedef struct {
      logic [DATA_W-1:0] data;
      logic [CHK_W-1:0]  chk;
      logic              ce;
      logic [DATA_W-1:0] exp_data;
      logic [HAM_W-1:0]  exp_syn;
      logic [1:0]        exp_err;
      int                exp_corr;
      int                exp_unc;
   } vec_t;

   vec_t vecs [11];

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CHK_W-1:0] c, input logic ce);
      in_valid = v;
      in_data  = d;
      in_chk   = c;
      corr_en  = ce;
   endtask

   // One isolated word on an idle pipeline; checks 2-cycle latency,
   // outputs, then the counters after the consumer takes it.
   task automatic apply_vec(input string tag, input vec_t v);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(1'b1, v.data, v.chk, v.ce);
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      check({tag, "_lat1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(v.exp_data));
      check({tag, "_syn"}, 64'(out_syndrome), 64'(v.exp_syn));
      check({tag, "_err"}, 64'(out_err), 64'(v.exp_err));
      @(negedge clk);
      check({tag, "_cnt_corr"}, 64'(cnt_corr), 64'(v.exp_corr));
      check({tag, "_cnt_unc"}, 64'(cnt_unc), 64'(v.exp_unc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- Test sequence ----------------
   initial begin
      logic [DATA_W-1:0] d;
      logic [CHK_W-1:0]  c;
      logic [DATA_W-1:0] bp_d [8];
      logic [CHK_W-1:0]  bp_c [8];
      int idx;
      int stall;
      bit started;
      vec_t v;

      vecs[0]  = '{32'h0000_0000, 7'h00, 1'b1, 32'h0000_0000, 6'd0,  2'b00, 0, 0};
      vecs[1]  = '{32'h0000_0001, 7'h00, 1'b1, 32'h0000_0000, 6'd3,  2'b01, 1, 0};
      vecs[2]  = '{32'h0000_0001, 7'h00, 1'b0, 32'h0000_0001, 6'd3,  2'b01, 2, 0};
      vecs[3]  = '{32'h0000_0003, 7'h00, 1'b1, 32'h0000_0003, 6'd6,  2'b11, 2, 1};
      vecs[4]  = '{32'h0000_0000, 7'h01, 1'b1, 32'h0000_0000, 6'd1,  2'b10, 3, 1};
      vecs[5]  = '{32'h0000_0000, 7'h40, 1'b1, 32'h0000_0000, 6'd0,  2'b10, 4, 1};
      vecs[6]  = '{32'h0000_0000, 7'h7F, 1'b1, 32'h0000_0000, 6'd63, 2'b11, 4, 2};
      vecs[7]  = '{32'h8000_0000, 7'h00, 1'b1, 32'h0000_0000, 6'd38, 2'b01, 5, 2};
      vecs[8]  = '{32'hFFFF_FFFF, 7'h18, 1'b1, 32'hFFFF_FFFF, 6'd0,  2'b00, 5, 2};
      vecs[9]  = '{32'hFFFF_FFEF, 7'h18, 1'b1, 32'hFFFF_FFFF, 6'd9,  2'b01, 6, 2};
      vecs[10] = '{32'h0000_0000, 7'h20, 1'b1, 32'h0000_0000, 6'd32, 2'b10, 7, 2};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_syn", 64'(out_syndrome), 64'd0);
      check("rst_err", 64'(out_err), 64'd0);
      check("rst_cnt_corr", 64'(cnt_corr), 64'd0);
      check("rst_cnt_unc", 64'(cnt_unc), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1;

      // Directed table
      for (int i = 0; i < 11; i++) apply_vec($sformatf("v%0d", i), vecs[i]);

      // Saturation: 17 corrected words into a 4-bit counter
      @(posedge clk); #1;
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 32'h0000_0001, 7'h00, 1'($urandom_range(0, 1)));
         @(posedge clk); #1;
      end
      drive(1'b0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sat_cnt_corr", 64'(cnt_corr), 64'd15);

      // cnt_clr in the same cycle as an accepted uncorrectable word
      @(posedge clk); #1;
      drive(1'b1, 32'h0000_0003, 7'h00, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      cnt_clr = 1'b1;
      @(negedge clk);
      check("clr_word_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      check("clr_cnt_unc", 64'(cnt_unc), 64'd0);
      check("clr_cnt_corr", 64'(cnt_corr), 64'd0);

      // Backpressure: 8 words, consumer stalls 5 cycles after first output
      for (int i = 0; i < 8; i++) gen_word($urandom_range(0, 2), bp_d[i], bp_c[i]);
      idx = 0;
      stall = 0;
      started = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(1'b1, bp_d[0], bp_c[0], 1'b1);
      for (int t = 0; t < 60 && idx < 8; t++) begin
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         if (out_valid && !started) started = 1;
         @(posedge clk); #1;
         if (started && stall < 5) begin
            out_ready = 1'b0;
            stall++;
         end else out_ready = 1'b1;
         if (idx < 8) drive(1'b1, bp_d[idx], bp_c[idx], 1'b1);
         else drive(1'b0, '0, '0, 1'b0);
      end
      check("bp_all_accepted", 64'(idx), 64'd8);
      check("bp_stall_cycles", 64'(stall), 64'd5);
      drive(1'b0, '0, '0, 1'b0);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Random phase
      for (int t = 0; t < 400; t++) begin
         @(posedge clk); #1;
         gen_word($urandom_range(0, 3), d, c);
         drive(1'($urandom_range(0, 3) != 0), d, c, 1'($urandom_range(0, 1)));
         out_ready = 1'($urandom_range(0, 3) != 0);
         cnt_clr   = 1'($urandom_range(0, 29) == 0);
      end
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b0);
      out_ready = 1'b1;
      cnt_clr = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("rand_drained", 64'(exp_q.size()), 64'd0);

      // Reset with both stages full
      @(posedge clk); #1;
      drive(1'b1, 32'h0000_0001, 7'h00, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_cnt_corr", 64'(cnt_corr), 64'd0);
      check("mrst_cnt_unc", 64'(cnt_unc), 64'd0);
      @(negedge clk);
      check("mrst_no_stale", 64'(out_valid), 64'd0);
      v = '{32'h0000_0001, 7'h00, 1'b1, 32'h0000_0000, 6'd3, 2'b01, 1, 0};
      apply_vec("mrst_next", v);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
